// File: rtl/cal_dsink_pkg.sv
// Shared calculator head definitions: data-bus destination codes, the
// default memory write buffer depth and a small destination decoder.
package cal_dsink_pkg;

  localparam logic [1:0] DMUX_MEM    = 2'b00;
  localparam logic [1:0] DMUX_CPU    = 2'b01;
  localparam logic [1:0] DMUX_ACC    = 2'b10;
  localparam logic [1:0] DMUX_UNUSED = 2'b11;

  localparam int CAL_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    DEST_MEM = 2'd0,
    DEST_CPU = 2'd1,
    DEST_ACC = 2'd2
  } dest_e;

  // The unused code 2'b11 is steered to the CPU register.
  function automatic dest_e destOf(input logic [1:0] dsel);
    dest_e d;
    d = DEST_CPU;
    if (dsel == DMUX_MEM) d = DEST_MEM;
    else if (dsel == DMUX_ACC) d = DEST_ACC;
    return d;
  endfunction

endpackage

// File: rtl/cal_dsink_if.sv
// Bus bundle between the calculator data bus, the CPU/ACC destination
// registers and the memory write port of cal_dsink.
// Optional parity ports appear when CAL_BUS_PARITY_EN is defined.
interface cal_dsink_if #(
  parameter int DW = 8
);

  logic [DW-1:0] data_bus;
  logic [1:0]    dsel;
  logic          bus_vld;
  logic          bus_rdy;
  logic [DW-1:0] cpu_data_in;
  logic [DW-1:0] acc_data_in;
  logic          cpu_ld;
  logic          acc_ld;
  logic [DW-1:0] mem_data_in;
  logic          mem_we;
  logic          mem_rdy;
`ifdef CAL_BUS_PARITY_EN
  logic          bus_par;
  logic          bus_err;

  modport master (
    output data_bus, dsel, bus_vld, mem_rdy, bus_par,
    input  bus_rdy, cpu_data_in, acc_data_in, cpu_ld, acc_ld,
           mem_data_in, mem_we, bus_err
  );

  modport slave (
    input  data_bus, dsel, bus_vld, mem_rdy, bus_par,
    output bus_rdy, cpu_data_in, acc_data_in, cpu_ld, acc_ld,
           mem_data_in, mem_we, bus_err
  );
`else
  modport master (
    output data_bus, dsel, bus_vld, mem_rdy,
    input  bus_rdy, cpu_data_in, acc_data_in, cpu_ld, acc_ld,
           mem_data_in, mem_we
  );

  modport slave (
    input  data_bus, dsel, bus_vld, mem_rdy,
    output bus_rdy, cpu_data_in, acc_data_in, cpu_ld, acc_ld,
           mem_data_in, mem_we
  );
`endif

endinterface

// File: rtl/cal_sync_fifo.sv
// Small synchronous FIFO used as the memory write buffer. The head word is
// presented combinationally and reads as zero while the buffer is empty.
module cal_sync_fifo #(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic [DW-1:0] o_head
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_FULL = FIFO_DEPTH[AW:0];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
    end
  end

  // Storage needs no reset: an empty buffer never exposes its contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/cal_dsink.sv
// Calculator data-bus sink: routes each bus transfer to the CPU register,
// the ACC register (each with a one-cycle load strobe) or the memory write
// buffer. Define CAL_BUS_PARITY_EN to add odd-parity checking with a sticky
// error flag; the default build accepts every transfer.
module cal_dsink
  import cal_dsink_pkg::*;
#(
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = CAL_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  cal_dsink_if.slave  bus
);

  logic          w_full;
  logic          w_empty;
  logic [DW-1:0] w_head;
  logic          w_xfer;
  logic          w_par_ok;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_to_cpu;
  logic          w_to_acc;
  dest_e         w_dest;

  logic [DW-1:0] r_cpu_data;
  logic [DW-1:0] r_acc_data;
  logic          r_cpu_ld;
  logic          r_acc_ld;

  assign w_xfer   = bus.bus_vld && !w_full;
  assign w_accept = w_xfer && w_par_ok;
  assign w_dest   = destOf(bus.dsel);
  assign w_push   = w_accept && (w_dest == DEST_MEM);
  assign w_to_cpu = w_accept && (w_dest == DEST_CPU);
  assign w_to_acc = w_accept && (w_dest == DEST_ACC);
  assign w_pop    = !w_empty && bus.mem_rdy;

`ifdef CAL_BUS_PARITY_EN
  logic r_bus_err;

  assign w_par_ok    = ^{bus.data_bus, bus.bus_par};
  assign bus.bus_err = r_bus_err;

  // A transfer with bad parity is dropped and latches the error until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_bus_err <= 1'b0;
    else if (w_xfer && !w_par_ok) r_bus_err <= 1'b1;
  end
`else
  assign w_par_ok = 1'b1;
`endif

  // Destination registers load on their transfer; strobes last one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_data <= '0;
      r_acc_data <= '0;
      r_cpu_ld   <= 1'b0;
      r_acc_ld   <= 1'b0;
    end else begin
      r_cpu_ld <= w_to_cpu;
      r_acc_ld <= w_to_acc;
      if (w_to_cpu) r_cpu_data <= bus.data_bus;
      if (w_to_acc) r_acc_data <= bus.data_bus;
    end
  end

  cal_sync_fifo #(
    .DW         (DW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (bus.data_bus),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign bus.bus_rdy     = !w_full;
  assign bus.mem_we      = !w_empty;
  assign bus.mem_data_in = w_head;
  assign bus.cpu_data_in = r_cpu_data;
  assign bus.acc_data_in = r_acc_data;
  assign bus.cpu_ld      = r_cpu_ld;
  assign bus.acc_ld      = r_acc_ld;

endmodule

// File: tb/tb_cal_dsink.sv
// Testbench for cal_dsink: directed scenarios plus randomized traffic,
// checked against a queue-based model of the sink. Honors CAL_BUS_PARITY_EN.
module tb_cal_dsink;
  import cal_dsink_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = CAL_FIFO_DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cal_dsink_if #(.DW(DW)) bus();

  cal_dsink #(.DW(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered memory words plus expected register state.
  logic [7:0] mq[$];
  logic [7:0] expCpu, expAcc;
  logic       expCpuLd, expAccLd, expErr;

  // Drives a bus transfer request with correct parity when parity exists.
  task automatic applyStimulus(input logic vld, input logic [1:0] sel, input logic [7:0] d);
    bus.bus_vld  = vld;
    bus.dsel     = sel;
    bus.data_bus = d;
`ifdef CAL_BUS_PARITY_EN
    bus.bus_par  = ~^d;
`endif
  endtask

  task automatic modelReset();
    mq.delete();
    expCpu = '0; expAcc = '0;
    expCpuLd = 1'b0; expAccLd = 1'b0; expErr = 1'b0;
  endtask

  // Advances one clock and applies the transfer rules to the model.
  task automatic clockCycle();
    bit rdy, we, xfer, ok, mrdy;
    logic [7:0] d;
    logic [1:0] s;
    rdy  = mq.size() < DEPTH;
    we   = mq.size() != 0;
    mrdy = bus.mem_rdy;
    ok   = 1'b1;
`ifdef CAL_BUS_PARITY_EN
    ok   = ^{bus.data_bus, bus.bus_par};
`endif
    xfer = bus.bus_vld && rdy;
    d = bus.data_bus;
    s = bus.dsel;
    @(posedge clk);
    expCpuLd = 1'b0;
    expAccLd = 1'b0;
    if (we && mrdy) void'(mq.pop_front());
    if (xfer && !ok) expErr = 1'b1;
    else if (xfer) begin
      if (s == DMUX_MEM) mq.push_back(d);
      else if (s == DMUX_ACC) begin expAcc = d; expAccLd = 1'b1; end
      else begin expCpu = d; expCpuLd = 1'b1; end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(1'b0, DMUX_MEM, 8'h00);
    bus.mem_rdy = 1'b0;
    modelReset();
    #2;
    checks++; if (bus.bus_rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_bus_rdy actual=%b expected=1", bus.bus_rdy); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we actual=%b expected=0", bus.mem_we); end
    checks++; if (bus.cpu_ld !== 1'b0 || bus.acc_ld !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobes actual=%b%b expected=00", bus.cpu_ld, bus.acc_ld); end
    checks++; if (bus.cpu_data_in !== 8'h00 || bus.acc_data_in !== 8'h00 || bus.mem_data_in !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_data actual=%h/%h/%h expected=00/00/00", bus.cpu_data_in, bus.acc_data_in, bus.mem_data_in);
    end
`ifdef CAL_BUS_PARITY_EN
    checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus_err actual=%b expected=0", bus.bus_err); end
`endif
    #1 rst_n = 1'b1;
  endtask

  // Transfer is presented right after reset release, so it also shows the
  // first edge after release accepts it.
  task automatic test_acc_load();
    applyStimulus(1'b1, DMUX_ACC, 8'h5A);
    clockCycle();
    applyStimulus(1'b0, DMUX_MEM, 8'h00);
    checks++; if (bus.acc_data_in !== 8'h5A) begin errors++; $display("[TB] FAIL acc_data actual=%h expected=5a", bus.acc_data_in); end
    checks++; if (bus.acc_ld !== 1'b1) begin errors++; $display("[TB] FAIL acc_ld_pulse actual=%b expected=1", bus.acc_ld); end
    checks++; if (bus.cpu_ld !== 1'b0) begin errors++; $display("[TB] FAIL acc_cpu_ld actual=%b expected=0", bus.cpu_ld); end
    clockCycle();
    checks++; if (bus.acc_ld !== 1'b0 || bus.cpu_ld !== 1'b0) begin errors++; $display("[TB] FAIL acc_ld_end actual=%b%b expected=00", bus.acc_ld, bus.cpu_ld); end
  endtask

  task automatic test_code11();
    applyStimulus(1'b1, DMUX_UNUSED, 8'h7E);
    clockCycle();
    applyStimulus(1'b0, DMUX_MEM, 8'h00);
    checks++; if (bus.cpu_data_in !== 8'h7E || bus.cpu_ld !== 1'b1) begin errors++; $display("[TB] FAIL code11_cpu actual=%h/%b expected=7e/1", bus.cpu_data_in, bus.cpu_ld); end
    checks++; if (bus.acc_ld !== 1'b0 || bus.acc_data_in !== 8'h5A) begin errors++; $display("[TB] FAIL code11_acc actual=%h/%b expected=5a/0", bus.acc_data_in, bus.acc_ld); end
    clockCycle();
    checks++; if (bus.cpu_ld !== 1'b0) begin errors++; $display("[TB] FAIL code11_ld_end actual=%b expected=0", bus.cpu_ld); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] pat [6] = '{DMUX_CPU, DMUX_CPU, DMUX_ACC, DMUX_ACC, DMUX_CPU, DMUX_ACC};
    logic [7:0] d;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      applyStimulus(1'b1, pat[i], d);
      clockCycle();
      checks++;
      if (bus.cpu_ld !== (pat[i] == DMUX_CPU) || bus.acc_ld !== (pat[i] == DMUX_ACC)) begin
        errors++; $display("[TB] FAIL b2b_strobe[%0d] actual=%b%b expected=%b%b", i, bus.cpu_ld, bus.acc_ld, pat[i] == DMUX_CPU, pat[i] == DMUX_ACC);
      end
      checks++;
      if ((pat[i] == DMUX_CPU ? bus.cpu_data_in : bus.acc_data_in) !== d) begin
        errors++; $display("[TB] FAIL b2b_data[%0d] actual=%h/%h expected=%h", i, bus.cpu_data_in, bus.acc_data_in, d);
      end
    end
    applyStimulus(1'b0, DMUX_MEM, 8'h00);
    clockCycle();
    checks++; if (bus.cpu_ld !== 1'b0 || bus.acc_ld !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle actual=%b%b expected=00", bus.cpu_ld, bus.acc_ld); end
  endtask

  task automatic test_mem_backpressure();
    logic [7:0] got[$];
    bus.mem_rdy = 1'b0;
    applyStimulus(1'b1, DMUX_MEM, 8'h11); clockCycle();
    applyStimulus(1'b1, DMUX_MEM, 8'h22); clockCycle();
    applyStimulus(1'b1, DMUX_MEM, 8'h33);
    checks++; if (bus.bus_rdy !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_rdy actual=%b expected=0", bus.bus_rdy); end
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_data_in !== 8'h11) begin errors++; $display("[TB] FAIL bp_head actual=%b/%h expected=1/11", bus.mem_we, bus.mem_data_in); end
    clockCycle();
    checks++; if (bus.bus_rdy !== 1'b0 || bus.mem_data_in !== 8'h11) begin errors++; $display("[TB] FAIL bp_held actual=%b/%h expected=0/11", bus.bus_rdy, bus.mem_data_in); end
    bus.mem_rdy = 1'b1;
    #1;
    checks++; if (bus.bus_rdy !== 1'b0) begin errors++; $display("[TB] FAIL bp_same_cycle_rdy actual=%b expected=0", bus.bus_rdy); end
    if (bus.mem_we === 1'b1) got.push_back(bus.mem_data_in);
    clockCycle();
    checks++; if (bus.bus_rdy !== 1'b1) begin errors++; $display("[TB] FAIL bp_rdy_after_pop actual=%b expected=1", bus.bus_rdy); end
    if (bus.mem_we === 1'b1) got.push_back(bus.mem_data_in);
    clockCycle();
    applyStimulus(1'b0, DMUX_MEM, 8'h00);
    if (bus.mem_we === 1'b1) got.push_back(bus.mem_data_in);
    clockCycle();
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained actual=%b expected=0", bus.mem_we); end
    checks++;
    if (got.size() != 3 || got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33) begin
      errors++; $display("[TB] FAIL bp_order actual=%p expected=11,22,33", got);
    end
    bus.mem_rdy = 1'b0;
  endtask

  task automatic test_push_pop_same();
    bus.mem_rdy = 1'b0;
    applyStimulus(1'b1, DMUX_MEM, 8'h55);
    clockCycle();
    bus.mem_rdy = 1'b1;
    applyStimulus(1'b1, DMUX_MEM, 8'hA0);
    checks++; if (bus.mem_data_in !== 8'h55) begin errors++; $display("[TB] FAIL pp_head_before actual=%h expected=55", bus.mem_data_in); end
    clockCycle();
    applyStimulus(1'b0, DMUX_MEM, 8'h00);
    bus.mem_rdy = 1'b0;
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_data_in !== 8'hA0 || bus.bus_rdy !== 1'b1) begin
      errors++; $display("[TB] FAIL pp_head_after actual=%b/%h/%b expected=1/a0/1", bus.mem_we, bus.mem_data_in, bus.bus_rdy);
    end
    bus.mem_rdy = 1'b1;
    clockCycle();
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL pp_count_one actual=%b expected=0", bus.mem_we); end
    bus.mem_rdy = 1'b0;
  endtask

`ifdef CAL_BUS_PARITY_EN
  task automatic test_parity();
    logic [7:0] prevCpu;
    prevCpu = expCpu;
    applyStimulus(1'b1, DMUX_CPU, 8'h01);
    bus.bus_par = 1'b1;
    clockCycle();
    applyStimulus(1'b0, DMUX_MEM, 8'h00);
    checks++; if (bus.cpu_ld !== 1'b0 || bus.cpu_data_in !== prevCpu) begin errors++; $display("[TB] FAIL par_dropped actual=%b/%h expected=0/%h", bus.cpu_ld, bus.cpu_data_in, prevCpu); end
    checks++; if (bus.bus_err !== 1'b1) begin errors++; $display("[TB] FAIL par_err_set actual=%b expected=1", bus.bus_err); end
    applyStimulus(1'b1, DMUX_CPU, 8'h02);
    clockCycle();
    applyStimulus(1'b0, DMUX_MEM, 8'h00);
    checks++; if (bus.cpu_ld !== 1'b1 || bus.cpu_data_in !== 8'h02) begin errors++; $display("[TB] FAIL par_good_load actual=%b/%h expected=1/02", bus.cpu_ld, bus.cpu_data_in); end
    checks++; if (bus.bus_err !== 1'b1) begin errors++; $display("[TB] FAIL par_err_sticky actual=%b expected=1", bus.bus_err); end
  endtask
`endif

  task automatic test_reset_midop();
    bus.mem_rdy = 1'b0;
    applyStimulus(1'b1, DMUX_MEM, 8'($urandom)); clockCycle();
    applyStimulus(1'b1, DMUX_MEM, 8'($urandom)); clockCycle();
    applyStimulus(1'b0, DMUX_MEM, 8'h00);
    checks++; if (bus.mem_we !== 1'b1 || bus.bus_rdy !== 1'b0) begin errors++; $display("[TB] FAIL mid_two_buffered actual=%b/%b expected=1/0", bus.mem_we, bus.bus_rdy); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_we !== 1'b0 || bus.bus_rdy !== 1'b1 || bus.mem_data_in !== 8'h00) begin
      errors++; $display("[TB] FAIL mid_async_clear actual=%b/%b/%h expected=0/1/00", bus.mem_we, bus.bus_rdy, bus.mem_data_in);
    end
    modelReset();
    #4 rst_n = 1'b1;
    bus.mem_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clockCycle();
      checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_write[%0d] actual=%b expected=0", i, bus.mem_we); end
    end
    bus.mem_rdy = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom));
`ifdef CAL_BUS_PARITY_EN
      if ($urandom_range(0, 7) == 0) bus.bus_par = ~bus.bus_par;
`endif
      bus.mem_rdy = 1'($urandom_range(0, 2) != 0);
      checks++; if (bus.bus_rdy !== (mq.size() < DEPTH)) begin errors++; $display("[TB] FAIL rnd_bus_rdy[%0d] actual=%b expected=%b", i, bus.bus_rdy, mq.size() < DEPTH); end
      checks++; if (bus.mem_we !== (mq.size() != 0)) begin errors++; $display("[TB] FAIL rnd_mem_we[%0d] actual=%b expected=%b", i, bus.mem_we, mq.size() != 0); end
      if (mq.size() != 0) begin
        checks++; if (bus.mem_data_in !== mq[0]) begin errors++; $display("[TB] FAIL rnd_mem_data[%0d] actual=%h expected=%h", i, bus.mem_data_in, mq[0]); end
      end
      checks++; if (bus.cpu_ld !== expCpuLd || bus.acc_ld !== expAccLd) begin errors++; $display("[TB] FAIL rnd_strobes[%0d] actual=%b%b expected=%b%b", i, bus.cpu_ld, bus.acc_ld, expCpuLd, expAccLd); end
      checks++; if (bus.cpu_data_in !== expCpu || bus.acc_data_in !== expAcc) begin errors++; $display("[TB] FAIL rnd_regs[%0d] actual=%h/%h expected=%h/%h", i, bus.cpu_data_in, bus.acc_data_in, expCpu, expAcc); end
`ifdef CAL_BUS_PARITY_EN
      checks++; if (bus.bus_err !== expErr) begin errors++; $display("[TB] FAIL rnd_bus_err[%0d] actual=%b expected=%b", i, bus.bus_err, expErr); end
`endif
      clockCycle();
    end
    applyStimulus(1'b0, DMUX_MEM, 8'h00);
  endtask

  initial begin
    test_reset();
    test_acc_load();
    test_code11();
    test_back_to_back();
    test_mem_backpressure();
    test_push_pop_same();
`ifdef CAL_BUS_PARITY_EN
    test_parity();
`endif
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cal_dsink.md
CAL_DSINK -- requirements
Module: cal_dsink

Interface
REQ-001 Parameter DW, default 8: data bus width.
REQ-002 Parameter FIFO_DEPTH, default 2: memory write buffer depth, a power of two of at least 2.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 data_bus  in  DW  shared calculator data bus value.
REQ-006 dsel  in  2  destination select, using the shared DMUX_MEM / DMUX_CPU / DMUX_ACC codes.
REQ-007 bus_vld  in  1  the bus carries a transfer this cycle.
REQ-008 bus_rdy  out  1  the sink accepts a transfer this cycle.
REQ-009 cpu_data_in, acc_data_in  out  DW each  latched destination registers.
REQ-010 cpu_ld, acc_ld  out  1 each  one-cycle load strobes.
REQ-011 mem_data_in  out  DW  head of the memory write buffer.
REQ-012 mem_we  out  1  memory write request.
REQ-013 mem_rdy  in  1  memory accepts the write.

Function
REQ-014 A transfer occurs when bus_vld && bus_rdy are high at a rising clk edge; no other bus activity has any effect.
REQ-015 bus_rdy = !fifo_full, independent of dsel (combinational).
REQ-016 Transfer with dsel=DMUX_CPU, or with the unused code 2'b11: cpu_data_in <= data_bus, and cpu_ld is high for exactly the next cycle.
REQ-017 Transfer with dsel=DMUX_ACC: acc_data_in <= data_bus, and acc_ld is high for exactly the next cycle.
REQ-018 Transfer with dsel=DMUX_MEM: data_bus is pushed into the FIFO; cpu and acc registers and strobes are unchanged.
REQ-019 mem_we = !fifo_empty; mem_data_in = FIFO head, valid whenever mem_we=1.
REQ-020 Pop occurs when mem_we && mem_rdy. mem_we stays high and mem_data_in stays stable until the pop.
REQ-021 Push and pop in the same cycle leave the count unchanged and preserve order.
REQ-022 First-word latency: a push at edge N gives mem_we=1 with that word in the cycle after edge N.
REQ-023 A full FIFO deasserts bus_rdy; a pop from full raises bus_rdy in the next cycle, never the same cycle.
REQ-024 FIFO pointers wrap modulo FIFO_DEPTH; the count width is log2(FIFO_DEPTH)+1 bits.
REQ-025 Back-to-back transfers every cycle are supported for CPU and ACC destinations; each one produces its own strobe.

Reset
REQ-026 While rst_n=0: FIFO is emptied, and cpu_data_in, acc_data_in and mem_data_in are 0.
REQ-027 While rst_n=0: cpu_ld, acc_ld and mem_we are 0, and bus_rdy is 1.
REQ-028 Reset asserted mid-operation discards buffered writes immediately, without waiting for a clock edge.
REQ-029 The first transfer is accepted at the first rising edge after rst_n deasserts.

Configuration
REQ-030 With CAL_BUS_PARITY_EN defined, two ports are added: bus_par (in, 1) and bus_err (out, 1).
REQ-031 With the macro defined, odd parity is checked over {data_bus, bus_par} on each transfer.
REQ-032 With the macro defined, a parity mismatch drops the transfer (no load, no push) and sets bus_err, which stays sticky until reset.
REQ-033 Without the macro, neither port exists and every transfer is accepted.

Structure
REQ-034 The DMUX_* destination codes and the default FIFO depth live in the shared cal_head definitions; no local redefinition is allowed.
REQ-035 The memory buffer is a sub-module named cal_sync_fifo, parameterised by DW and FIFO_DEPTH, providing push, pop, full, empty and head.

Verification
REQ-036 Scenario: reset release; dsel=DMUX_ACC, data_bus=8'h5A, bus_vld for 1 cycle -> acc_data_in=8'h5A and acc_ld pulses exactly 1 cycle; cpu_ld stays 0.
REQ-037 Scenario: with mem_rdy=0, three DMUX_MEM transfers 8'h11, 8'h22, 8'h33 -> first two are accepted and bus_rdy=0 while the third is held; after mem_rdy=1, writes emerge in order 11, 22, 33.
REQ-038 Scenario: FIFO holding one word, push 8'hA0 and pop in the same cycle -> count stays 1, and the head advances to 8'hA0 next.
REQ-039 Scenario: dsel=2'b11, data_bus=8'h7E -> cpu_data_in=8'h7E and cpu_ld pulses.
REQ-040 Scenario: rst_n pulled low for half a cycle with 2 words buffered -> mem_we=0 immediately and bus_rdy=1; no buffered word is written afterwards.
REQ-041 Scenario (CAL_BUS_PARITY_EN): data_bus=8'h01 with bus_par=1 -> transfer dropped and bus_err=1; a following correct transfer loads normally while bus_err stays 1.
